// File: rtl/adc_pkg.sv
// adc_pkg: shared widths, channel count, threshold defaults and level state type for the ADC filter
package adc_pkg;
    localparam int ADC_W  = 10;
    localparam int NUM_CH = 2;
    localparam logic [ADC_W-1:0] TH_HI_DEF = 10'd640;
    localparam logic [ADC_W-1:0] TH_LO_DEF = 10'd384;
    typedef enum logic [1:0] {WARMUP, LOW, HIGH} lvl_state_t;
endpackage

// File: rtl/adc_ch_filter.sv
// adc_ch_filter: one channel's boxcar window, running sum, fill count and hysteresis detector
module adc_ch_filter
    import adc_pkg::*;
#(
    parameter int               AVG_LOG2 = 3,
    parameter logic [ADC_W-1:0] TH_HI    = TH_HI_DEF,
    parameter logic [ADC_W-1:0] TH_LO    = TH_LO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             take,
    input  logic             upd,
    input  logic [ADC_W-1:0] word,
    output logic [ADC_W-1:0] avg,
    output logic             level,
    output logic             rise,
    output logic             fall
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = ADC_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2+1)'(DEPTH);

    logic [SW-1:0]       sum;
    logic [ADC_W-1:0]    win [DEPTH];
    logic [AVG_LOG2-1:0] ptr;
    logic [AVG_LOG2:0]   fill;
    lvl_state_t          state, nxt;
    logic [ADC_W-1:0]    avg_n;
    logic                rise_n, fall_n, flush;

    assign flush = !rst || clear;
    assign level = state == HIGH;

    // The oldest sample leaves the sum as the new one overwrites its slot
    always_ff @(posedge clk) begin
        if (flush) begin
            sum  <= '0;
            ptr  <= '0;
            fill <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else if (take) begin
            sum      <= sum + SW'(word) - SW'(win[ptr]);
            win[ptr] <= word;
            ptr      <= ptr + 1'b1;
            fill     <= (fill == FULL) ? fill : fill + 1'b1;
        end
    end

    always_comb begin
        avg_n  = ADC_W'(sum >> AVG_LOG2);
        nxt    = state;
        rise_n = 1'b0;
        fall_n = 1'b0;
        unique case (state)
            WARMUP: if (fill == FULL) nxt = (avg_n >= TH_HI) ? HIGH : LOW;
            LOW:    if (avg_n >= TH_HI) begin
                        nxt    = HIGH;
                        rise_n = 1'b1;
                    end
            HIGH:   if (avg_n <= TH_LO) begin
                        nxt    = LOW;
                        fall_n = 1'b1;
                    end
            default: nxt = WARMUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state <= WARMUP;
            avg   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else if (upd) begin
            state <= nxt;
            avg   <= avg_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end else begin
            rise  <= 1'b0;
            fall  <= 1'b0;
        end
    end
endmodule

// File: rtl/adc_sample_filter.sv
// adc_sample_filter: two-channel moving-average and hysteresis filter for MCP3008 sample pairs
module adc_sample_filter
    import adc_pkg::*;
#(
    parameter int               AVG_LOG2 = 3,
    parameter logic [ADC_W-1:0] TH_HI    = TH_HI_DEF,
    parameter logic [ADC_W-1:0] TH_LO    = TH_LO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [ADC_W-1:0] ch0_word,
    input  logic [ADC_W-1:0] ch1_word,
    input  logic             valid,
    output logic [ADC_W-1:0] ch0_avg,
    output logic [ADC_W-1:0] ch1_avg,
    output logic             avg_valid,
    output logic             ch0_level,
    output logic             ch1_level,
    output logic             ch0_rise,
    output logic             ch0_fall,
    output logic             ch1_rise,
    output logic             ch1_fall
);
    logic pend;

    // pend marks a sample whose sum is updated and whose average lands next cycle
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            pend      <= 1'b0;
            avg_valid <= 1'b0;
        end else begin
            pend      <= valid;
            avg_valid <= pend;
        end
    end

    adc_ch_filter #(.AVG_LOG2(AVG_LOG2), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch0 (
        .clk(clk), .rst(rst), .clear(clear), .take(valid), .upd(pend), .word(ch0_word),
        .avg(ch0_avg), .level(ch0_level), .rise(ch0_rise), .fall(ch0_fall)
    );

    adc_ch_filter #(.AVG_LOG2(AVG_LOG2), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch1 (
        .clk(clk), .rst(rst), .clear(clear), .take(valid), .upd(pend), .word(ch1_word),
        .avg(ch1_avg), .level(ch1_level), .rise(ch1_rise), .fall(ch1_fall)
    );
endmodule

// File: tb/tb_adc_sample_filter.sv
// tb_adc_sample_filter: directed and randomized checks of adc_sample_filter against a queue-based model
module tb_adc_sample_filter;
    logic       clk = 1'b0, rst = 1'b0, clear = 1'b0, valid = 1'b0;
    logic [9:0] ch0_word = '0, ch1_word = '0;
    logic [9:0] ch0_avg, ch1_avg;
    logic       avg_valid, ch0_level, ch1_level, ch0_rise, ch0_fall, ch1_rise, ch1_fall;

    always #5 clk = ~clk;

    adc_sample_filter dut (
        .clk(clk), .rst(rst), .clear(clear), .ch0_word(ch0_word), .ch1_word(ch1_word),
        .valid(valid), .ch0_avg(ch0_avg), .ch1_avg(ch1_avg), .avg_valid(avg_valid),
        .ch0_level(ch0_level), .ch1_level(ch1_level), .ch0_rise(ch0_rise),
        .ch0_fall(ch0_fall), .ch1_rise(ch1_rise), .ch1_fall(ch1_fall)
    );

    int n_chk = 0, n_err = 0;
    int n_rise0, n_fall0, n_ev;

    // model: last 8 samples per channel, shared fill count, level state 0=warmup 1=low 2=high
    int h0[$], h1[$];
    int nfill, st[2];
    bit p_v, e_av;
    int p_avg[2], e_avg[2];
    bit p_lvl[2], p_rise[2], p_fall[2], e_lvl[2], e_rise[2], e_fall[2];

    task automatic check(input string tag, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int push_avg(input int ch, input int w);
        int s = 0;
        if (ch == 0) begin
            h0.push_back(w);
            if (h0.size() > 8) void'(h0.pop_front());
            foreach (h0[i]) s += h0[i];
        end else begin
            h1.push_back(w);
            if (h1.size() > 8) void'(h1.pop_front());
            foreach (h1[i]) s += h1[i];
        end
        return s / 8;
    endfunction

    task automatic model(input bit rn, input bit clr, input bit v, input int w0, input int w1);
        int w[2];
        w[0] = w0;
        w[1] = w1;
        if (!rn || clr) begin
            h0.delete();
            h1.delete();
            nfill = 0;
            p_v = 0;
            e_av = 0;
            for (int c = 0; c < 2; c++) begin
                st[c] = 0; e_avg[c] = 0; e_lvl[c] = 0; e_rise[c] = 0; e_fall[c] = 0;
            end
        end else begin
            e_av = p_v;
            for (int c = 0; c < 2; c++) begin
                e_rise[c] = p_v && p_rise[c];
                e_fall[c] = p_v && p_fall[c];
                if (p_v) begin
                    e_avg[c] = p_avg[c];
                    e_lvl[c] = p_lvl[c];
                end
            end
            p_v = v;
            if (v) begin
                nfill++;
                for (int c = 0; c < 2; c++) begin
                    p_avg[c] = push_avg(c, w[c]);
                    p_rise[c] = 0;
                    p_fall[c] = 0;
                    if (st[c] == 0) begin
                        if (nfill == 8) st[c] = (p_avg[c] >= 640) ? 2 : 1;
                    end else if (st[c] == 1 && p_avg[c] >= 640) begin
                        st[c] = 2; p_rise[c] = 1;
                    end else if (st[c] == 2 && p_avg[c] <= 384) begin
                        st[c] = 1; p_fall[c] = 1;
                    end
                    p_lvl[c] = st[c] == 2;
                end
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit clr, input bit v, input int w0, input int w1);
        rst = rn;
        clear = clr;
        valid = v;
        ch0_word = 10'(w0);
        ch1_word = 10'(w1);
        @(posedge clk);
        model(rn, clr, v, w0, w1);
        #1;
        check("avg_valid", avg_valid, e_av);
        check("ch0_avg", ch0_avg, e_avg[0]);
        check("ch1_avg", ch1_avg, e_avg[1]);
        check("ch0_level", ch0_level, e_lvl[0]);
        check("ch1_level", ch1_level, e_lvl[1]);
        check("ch0_rise", ch0_rise, e_rise[0]);
        check("ch0_fall", ch0_fall, e_fall[0]);
        check("ch1_rise", ch1_rise, e_rise[1]);
        check("ch1_fall", ch1_fall, e_fall[1]);
        n_rise0 += int'(ch0_rise);
        n_fall0 += int'(ch0_fall);
        n_ev += int'(ch0_rise) + int'(ch0_fall) + int'(ch1_rise) + int'(ch1_fall);
    endtask

    task automatic feed(input int w0, input int w1);
        cyc(1, 0, 1, w0, w1);
        repeat (3) cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        int base, j0, j1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0);
        repeat (8) feed(512, 100);
        check("warm_exit_avg", ch0_avg, 512);
        check("warm_exit_lvl", ch0_level, 0);
        repeat (8) feed(100, 100);
        n_rise0 = 0;
        n_fall0 = 0;
        repeat (8) feed(1023, 100);
        check("rise_count", n_rise0, 1);
        check("hi_avg", ch0_avg, 1023);
        repeat (8) feed(0, 100);
        check("fall_count", n_fall0, 1);
        n_ev = 0;
        for (int i = 0; i < 16; i++) feed((i % 2) ? 600 : 400, 500);
        check("band_events", n_ev, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, $urandom_range(0, 1023), $urandom_range(0, 1023));
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 900, 900);
        cyc(1, 1, 1, 1000, 1000);
        repeat (3) cyc(1, 0, 0, 0, 0);
        n_ev = 0;
        repeat (8) feed(1023, 1023);
        check("clear_events", n_ev, 0);
        check("clear_refill_lvl", ch1_level, 1);
        cyc(1, 0, 1, 10, 10);
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        check("rst_flush_avg", ch0_avg, 0);
        base = 500;
        for (int i = 0; i < 600; i++) begin
            if (i % 32 == 0) base = $urandom_range(0, 1023);
            j0 = base + $urandom_range(0, 200) - 100;
            j1 = 1023 - j0;
            j0 = (j0 < 0) ? 0 : (j0 > 1023) ? 1023 : j0;
            j1 = (j1 < 0) ? 0 : (j1 > 1023) ? 1023 : j1;
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 2) == 0, j0, j1);
        end
        repeat (3) cyc(1, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
